// File: rtl/an_decode_arb_n13.sv
// ---------------------------------------------------------------------------
// an_decode_arb_n13
// Two-requester round-robin front end feeding one shared AN (A=13) decoder.
// A granted 6-bit codeword is captured, decoded via Barrett reduction in the
// next cycle, then held on the out_* port until the consumer accepts it.
// Delivered results with a nonzero residue are counted in a saturating
// error counter.
//
// Ports
//   clk, rst_n             clock, async active-low reset
//   req0_valid/cw/ready    requester 0 codeword handshake
//   req1_valid/cw/ready    requester 1 codeword handshake
//   out_valid/out_ready    result handshake
//   out_id                 requester that owns the result
//   out_q, out_r           Barrett quotient / residue
//   out_err, out_msg       corruption flag / decoded message
//   cnt_clr                synchronous clear of err_cnt
//   err_cnt                saturating count of delivered errored results
// ---------------------------------------------------------------------------

// Barrett reduction of a 6-bit value by 13: q_est = (cw*19)>>8 can fall one
// short of the true quotient for cw < 64, so a single correction step fixes it.
module barrett_n13 (
    input  logic [5:0] cw,
    output logic [2:0] q,
    output logic [3:0] r
);
    logic [10:0] prod;
    logic [2:0]  q_est;
    logic [6:0]  r_est;

    always_comb begin
        prod  = 11'(cw) * 11'd19;
        q_est = prod[10:8];
        r_est = 7'(cw) - 7'(q_est) * 7'd13;
        if (r_est >= 7'd13) begin
            q = q_est + 3'd1;
            r = 4'(r_est - 7'd13);
        end else begin
            q = q_est;
            r = r_est[3:0];
        end
    end
endmodule

// AN decode: a valid codeword is a multiple of 13, the quotient is the message.
module an_decoder_n13 (
    input  logic [2:0] q,
    input  logic [3:0] r,
    output logic       err,
    output logic [2:0] msg
);
    assign err = (r != 4'd0);
    assign msg = q;
endmodule

module an_decode_arb_n13 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [5:0]       req0_cw,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [5:0]       req1_cw,
    output logic             req1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_id,
    output logic [2:0]       out_q,
    output logic [3:0]       out_r,
    output logic             out_err,
    output logic [2:0]       out_msg,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_cnt
);
    typedef enum logic [1:0] {IDLE, DECODE, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [5:0]       cw_q, cw_d;
    logic             id_q, id_d;
    logic             out_id_q, out_id_d;
    logic [2:0]       out_q_q, out_q_d;
    logic [3:0]       out_r_q, out_r_d;
    logic             out_err_q, out_err_d;
    logic [2:0]       out_msg_q, out_msg_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             gnt;
    logic [2:0]       dec_q;
    logic [3:0]       dec_r;
    logic             dec_err;
    logic [2:0]       dec_msg;

    barrett_n13 u_barrett (
        .cw (cw_q),
        .q  (dec_q),
        .r  (dec_r)
    );

    an_decoder_n13 u_dec (
        .q   (dec_q),
        .r   (dec_r),
        .err (dec_err),
        .msg (dec_msg)
    );

    // Under contention the requester not granted last wins; a lone valid wins.
    assign gnt = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    // rst_n gates the readies so nothing looks accepted while reset is held.
    assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !gnt;
    assign req1_ready = rst_n && (state_q == IDLE) && req1_valid && gnt;

    assign out_valid = (state_q == HOLD);
    assign out_id    = out_id_q;
    assign out_q     = out_q_q;
    assign out_r     = out_r_q;
    assign out_err   = out_err_q;
    assign out_msg   = out_msg_q;
    assign err_cnt   = err_cnt_q;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cw_d      = cw_q;
        id_d      = id_q;
        out_id_d  = out_id_q;
        out_q_d   = out_q_q;
        out_r_d   = out_r_q;
        out_err_d = out_err_q;
        out_msg_d = out_msg_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    cw_d    = gnt ? req1_cw : req0_cw;
                    id_d    = gnt;
                    last_d  = gnt;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                out_id_d  = id_q;
                out_q_d   = dec_q;
                out_r_d   = dec_r;
                out_err_d = dec_err;
                out_msg_d = dec_msg;
                state_d   = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    if (out_err_q && (err_cnt_q != CNT_MAX))
                        err_cnt_d = err_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cnt_clr)
            err_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cw_q      <= '0;
            id_q      <= 1'b0;
            out_id_q  <= 1'b0;
            out_q_q   <= '0;
            out_r_q   <= '0;
            out_err_q <= 1'b0;
            out_msg_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cw_q      <= cw_d;
            id_q      <= id_d;
            out_id_q  <= out_id_d;
            out_q_q   <= out_q_d;
            out_r_q   <= out_r_d;
            out_err_q <= out_err_d;
            out_msg_q <= out_msg_d;
            err_cnt_q <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_an_decode_arb_n13.sv
module tb_an_decode_arb_n13;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [5:0]       req0_cw, req1_cw;
    logic             out_valid, out_ready, out_id, out_err;
    logic [2:0]       out_q, out_msg;
    logic [3:0]       out_r;
    logic             cnt_clr;
    logic [CNT_W-1:0] err_cnt;

    an_decode_arb_n13 #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_cw(req0_cw), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_cw(req1_cw), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_q(out_q), .out_r(out_r), .out_err(out_err), .out_msg(out_msg),
        .cnt_clr(cnt_clr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [2:0] q;
        logic [3:0] r;
        logic       err;
        logic [2:0] msg;
    } res_t;

    typedef struct {
        logic [5:0] cw;
        logic [2:0] q;
        logic [3:0] r;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t sb[$];
    int   id_log[$];
    int   m_cnt = 0;
    bit   in_flight = 0;
    int   lat = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference decode by plain division, independent of the Barrett datapath.
    function automatic res_t model(input logic id, input logic [5:0] cw);
        res_t o;
        int   qi = int'(cw) / 13;
        int   ri = int'(cw) % 13;
        o.id  = id;
        o.q   = 3'(qi);
        o.r   = 4'(ri);
        o.err = (ri != 0);
        o.msg = 3'(qi);
        return o;
    endfunction

    // Scoreboard/monitor, sampled on the falling edge.
    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            sb.delete();
            m_cnt     = 0;
            in_flight = 0;
            chk(!out_valid, "rst_out_valid", out_valid, 0);
            chk(!req0_ready && !req1_ready, "rst_ready", {req1_ready, req0_ready}, 0);
            chk(err_cnt == 0, "rst_err_cnt", err_cnt, 0);
        end else begin
            chk(int'(err_cnt) == m_cnt, "err_cnt", err_cnt, m_cnt);
            if (in_flight) begin
                lat++;
                if (lat == 1) chk(!out_valid, "lat1_valid", out_valid, 0);
                if (lat == 2) begin
                    chk(out_valid, "lat2_valid", out_valid, 1);
                    in_flight = 0;
                end
            end
            if (out_valid) begin
                chk(!req0_ready && !req1_ready, "hold_ready", {req1_ready, req0_ready}, 0);
                if (sb.size() == 0) begin
                    chk(0, "sb_empty", 1, 0);
                end else begin
                    e = sb[0];
                    chk(out_id == e.id, "out_id", out_id, e.id);
                    chk(out_q == e.q, "out_q", out_q, e.q);
                    chk(out_r == e.r, "out_r", out_r, e.r);
                    chk(out_err == e.err, "out_err", out_err, e.err);
                    chk(out_msg == e.msg, "out_msg", out_msg, e.msg);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        id_log.push_back(int'(e.id));
                        if (!cnt_clr && e.err && m_cnt < CMAX) m_cnt++;
                    end
                end
            end
            if (cnt_clr) m_cnt = 0;
            chk(!(req0_ready && req1_ready), "one_ready", {req1_ready, req0_ready}, 1);
            chk(!req0_ready || req0_valid, "r0_ready_valid", req0_ready, req0_valid);
            chk(!req1_ready || req1_valid, "r1_ready_valid", req1_ready, req1_valid);
            if (req0_ready) begin
                sb.push_back(model(1'b0, req0_cw));
                in_flight = 1; lat = 0;
            end
            if (req1_ready) begin
                sb.push_back(model(1'b1, req1_cw));
                in_flight = 1; lat = 0;
            end
        end
    end

    logic [2:0] got_q;
    logic [3:0] got_r;
    logic       got_err;
    logic       got_id;

    task automatic do_txn(input logic id, input logic [5:0] cw);
        bit acc = 0;
        bit got = 0;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1; req1_cw = cw; end
        else    begin req0_valid = 1; req0_cw = cw; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin acc = 1; break; end
        end
        if (!acc) chk(0, "accept_timeout", 0, 1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1;
                got_q = out_q; got_r = out_r; got_err = out_err; got_id = out_id;
                break;
            end
        end
        if (!got) chk(0, "result_timeout", 0, 1);
    endtask

    task automatic wait_out_valid();
        bit got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin got = 1; break; end
        end
        if (!got) chk(0, "out_valid_timeout", 0, 1);
    endtask

    vec_t vecs[11];

    initial begin
        logic [3:0] rec_r;
        logic [2:0] rec_q;
        logic       rec_id;

        vecs[0]  = '{6'd0,  3'd0, 4'd0};
        vecs[1]  = '{6'd13, 3'd1, 4'd0};
        vecs[2]  = '{6'd26, 3'd2, 4'd0};
        vecs[3]  = '{6'd27, 3'd2, 4'd1};
        vecs[4]  = '{6'd39, 3'd3, 4'd0};
        vecs[5]  = '{6'd51, 3'd3, 4'd12};
        vecs[6]  = '{6'd52, 3'd4, 4'd0};
        vecs[7]  = '{6'd63, 3'd4, 4'd11};
        vecs[8]  = '{6'd12, 3'd0, 4'd12};
        vecs[9]  = '{6'd25, 3'd1, 4'd12};
        vecs[10] = '{6'd40, 3'd3, 4'd1};

        rst_n = 1; req0_valid = 0; req1_valid = 0; req0_cw = 0; req1_cw = 0;
        out_ready = 1; cnt_clr = 0;
        #1 rst_n = 0;
        req0_valid = 1; req0_cw = 6'd26;
        repeat (2) @(negedge clk);
        chk(out_id == 0 && out_q == 0 && out_r == 0 && out_err == 0 && out_msg == 0,
            "rst_out_regs", {out_id, out_q, out_r, out_err, out_msg}, 0);
        @(posedge clk); #1;
        rst_n = 1; req0_valid = 0;

        // First transaction after reset: clean codeword.
        do_txn(1'b0, 6'd26);
        chk(got_id == 0 && got_q == 2 && got_r == 0 && got_err == 0, "first_txn",
            {got_id, got_q, got_r, got_err}, {1'b0, 3'd2, 4'd0, 1'b0});
        @(negedge clk);
        chk(err_cnt == 0, "first_cnt", err_cnt, 0);

        // Corrupted codeword from requester 1.
        do_txn(1'b1, 6'd27);
        chk(got_err == 1 && got_r == 1 && got_q == 2, "cw27", {got_q, got_r, got_err},
            {3'd2, 4'd1, 1'b1});
        @(negedge clk);
        chk(err_cnt == 1, "cnt_after_27", err_cnt, 1);

        // Table of hand-computed decodes, alternating requesters.
        for (int i = 0; i < 11; i++) begin
            do_txn(1'(i % 2), vecs[i].cw);
            chk(got_q == vecs[i].q, "tbl_q", got_q, vecs[i].q);
            chk(got_r == vecs[i].r, "tbl_r", got_r, vecs[i].r);
            chk(got_err == (vecs[i].r != 0), "tbl_err", got_err, vecs[i].r != 0);
            chk(got_id == 1'(i % 2), "tbl_id", got_id, i % 2);
        end
        @(negedge clk);
        chk(err_cnt == CMAX, "cnt_saturated", err_cnt, CMAX);

        // Back-pressure in HOLD with both requesters pushing.
        @(posedge clk); #1;
        out_ready = 0;
        req0_valid = 1; req0_cw = 6'd40;
        req1_valid = 1; req1_cw = 6'd63;
        wait_out_valid();
        rec_q = out_q; rec_r = out_r; rec_id = out_id;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk(out_valid, "stall_valid", out_valid, 1);
            chk(out_q == rec_q && out_r == rec_r && out_id == rec_id, "stall_stable",
                {out_id, out_q, out_r}, {rec_id, rec_q, rec_r});
            chk(sb.size() == 1, "stall_no_capture", sb.size(), 1);
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0; out_ready = 1;
        repeat (3) @(negedge clk);
        chk(sb.size() == 0, "stall_drained", sb.size(), 0);

        // Five more corrupted codewords: counter stays pinned at max.
        for (int i = 0; i < 5; i++) do_txn(1'b0, 6'(1 + i * 7));
        @(negedge clk);
        chk(err_cnt == CMAX, "sat_5err", err_cnt, CMAX);

        // Clear lands on the same edge as an error delivery.
        @(posedge clk); #1;
        out_ready = 0; req0_valid = 1; req0_cw = 6'd1;
        @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 0;
        wait_out_valid();
        @(posedge clk); #1;
        cnt_clr = 1; out_ready = 1;
        @(posedge clk); #1;
        cnt_clr = 0;
        chk(err_cnt == 0, "clr_priority", err_cnt, 0);

        do_txn(1'b1, 6'd2);
        @(negedge clk);
        chk(err_cnt == 1, "cnt_after_clr", err_cnt, 1);

        // Reset pulse while a result is held.
        @(posedge clk); #1;
        out_ready = 0; req0_valid = 1; req0_cw = 6'd27;
        @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 0;
        wait_out_valid();
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk(!out_valid, "rst_mid_valid", out_valid, 0);
        chk(err_cnt == 0, "rst_mid_cnt", err_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk(err_cnt == 0, "rst_mid_cnt_after", err_cnt, 0);

        // Continuous contention after reset: grants alternate from requester 0.
        id_log.delete();
        out_ready = 1;
        @(posedge clk); #1;
        req0_valid = 1; req0_cw = 6'd13;
        req1_valid = 1; req1_cw = 6'd39;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (id_log.size() >= 4) break;
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        repeat (4) @(negedge clk);
        chk(id_log.size() >= 4, "rr_count", id_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < id_log.size()) chk(id_log[i] == i % 2, "rr_order", id_log[i], i % 2);
        chk(sb.size() == 0, "final_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
